// File: rtl/bonus_hit_detector.sv
// Bonus-ship / player-fire hit detector: one registered hit pulse per frame, shot-indexed award,
// frame-counted explosion window and latched hit coordinates.
module bonus_hit_detector #(
    parameter int SHOT_CYCLE     = 15,
    parameter int SPECIAL_SHOT   = 14,
    parameter int SCORE_SPECIAL  = 300,
    parameter int EXPLODE_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        playGame,
    input  logic        fireLaunch,
    input  logic        bonus_ship_DR,
    input  logic        playerFire_DR,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        bonusFireCollision,
    output logic        scoreValid,
    output logic [8:0]  scoreAdd,
    output logic        explodeActive,
    output logic [10:0] hitX,
    output logic [10:0] hitY
);

    localparam int SHOT_W = (SHOT_CYCLE > 4) ? $clog2(SHOT_CYCLE) : 2;
    localparam logic [SHOT_W-1:0] SHOT_LAST   = SHOT_W'(SHOT_CYCLE - 1);
    localparam logic [SHOT_W-1:0] SHOT_SPEC   = SHOT_W'(SPECIAL_SHOT);
    localparam logic [8:0]        AWARD_SPEC  = 9'(SCORE_SPECIAL);
    localparam logic [7:0]        FRAMES_LAST = 8'(EXPLODE_FRAMES);

    typedef enum logic {
        S_IDLE,
        S_EXPLODE
    } state_t;

    state_t             r_state;
    logic               r_frame_hit;
    logic [7:0]         r_frame_cnt;
    logic [SHOT_W-1:0]  r_shot_cnt;
    logic               r_collision;
    logic               r_score_valid;
    logic [8:0]         r_score_add;
    logic [10:0]        r_hit_x;
    logic [10:0]        r_hit_y;

    state_t             w_state_next;
    logic               w_frame_hit_next;
    logic [7:0]         w_frame_cnt_next;
    logic [SHOT_W-1:0]  w_shot_cnt_next;
    logic               w_collision_next;
    logic               w_score_valid_next;
    logic [8:0]         w_score_add_next;
    logic [10:0]        w_hit_x_next;
    logic [10:0]        w_hit_y_next;

    logic               w_overlap;
    logic               w_frame_hit_eff;
    logic               w_hit;
    logic [8:0]         w_award;

    // The frame-start clear is applied before the overlap test so a hit on that cycle counts for the new frame.
    assign w_overlap       = bonus_ship_DR & playerFire_DR & playGame;
    assign w_frame_hit_eff = r_frame_hit & ~startOfFrame;
    assign w_hit           = w_overlap & (r_state == S_IDLE) & ~w_frame_hit_eff;

    always_comb begin
        w_award = 9'd50;
        if (r_shot_cnt == SHOT_SPEC) begin
            w_award = AWARD_SPEC;
        end else begin
            case (r_shot_cnt[1:0])
                2'd0:    w_award = 9'd50;
                2'd1:    w_award = 9'd100;
                2'd2:    w_award = 9'd150;
                default: w_award = 9'd100;
            endcase
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_frame_cnt_next   = r_frame_cnt;
        w_frame_hit_next   = w_frame_hit_eff | w_hit;
        w_shot_cnt_next    = r_shot_cnt;
        w_collision_next   = w_hit;
        w_score_valid_next = w_hit;
        w_score_add_next   = w_hit ? w_award : 9'd0;
        w_hit_x_next       = w_hit ? pixelX : r_hit_x;
        w_hit_y_next       = w_hit ? pixelY : r_hit_y;

        if (fireLaunch && playGame) begin
            w_shot_cnt_next = (r_shot_cnt == SHOT_LAST) ? '0 : r_shot_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_next     = S_EXPLODE;
                    w_frame_cnt_next = 8'd0;
                end
            end
            S_EXPLODE: begin
                if (r_frame_cnt >= FRAMES_LAST) begin
                    w_state_next     = S_IDLE;
                    w_frame_cnt_next = 8'd0;
                end else if (startOfFrame) begin
                    w_frame_cnt_next = r_frame_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_frame_cnt_next = 8'd0;
            end
        endcase

        // Leaving the game abandons everything except the last hit position.
        if (!playGame) begin
            w_state_next       = S_IDLE;
            w_frame_cnt_next   = 8'd0;
            w_frame_hit_next   = 1'b0;
            w_shot_cnt_next    = '0;
            w_collision_next   = 1'b0;
            w_score_valid_next = 1'b0;
            w_score_add_next   = 9'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_frame_hit   <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_shot_cnt    <= '0;
            r_collision   <= 1'b0;
            r_score_valid <= 1'b0;
            r_score_add   <= 9'd0;
            r_hit_x       <= 11'd0;
            r_hit_y       <= 11'd0;
        end else begin
            r_state       <= w_state_next;
            r_frame_hit   <= w_frame_hit_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_shot_cnt    <= w_shot_cnt_next;
            r_collision   <= w_collision_next;
            r_score_valid <= w_score_valid_next;
            r_score_add   <= w_score_add_next;
            r_hit_x       <= w_hit_x_next;
            r_hit_y       <= w_hit_y_next;
        end
    end

    assign bonusFireCollision = r_collision;
    assign scoreValid         = r_score_valid;
    assign scoreAdd           = r_score_add;
    assign explodeActive      = (r_state == S_EXPLODE);
    assign hitX               = r_hit_x;
    assign hitY               = r_hit_y;

endmodule
